// File: rtl/memoria_pkg.sv
// Shared definitions for the instruction memory: NOP word, FSM state encoding
// and an elaboration-time log2 helper.
package memoria_pkg;

    // Wide enough for any realistic instruction width; users slice the low bits.
    localparam int unsigned ANCHO_NOP_MAX = 1024;
    localparam logic [ANCHO_NOP_MAX-1:0] NOP = '0;  // MIPS sll $0,$0,0

    typedef enum logic {
        ESTADO_CARGA     = 1'b0,
        ESTADO_EJECUCION = 1'b1
    } estado_e;

    // Ceiling log2; returns 0 for values 0 and 1.
    function automatic int unsigned clog2(input int unsigned valor);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(valor)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/memoria_instrucciones_param_if.sv
// Fetch bus between the PC/fetch stage (master) and the instruction memory (slave):
// request and response channels, each with a valid/ready handshake.
interface memoria_instrucciones_param_if #(
    parameter int unsigned ANCHO_DATOS = 32,
    parameter int unsigned ANCHO_DIR   = 32
);

    logic                   dir_valido;
    logic [ANCHO_DIR-1:0]   dir;
    logic                   dir_listo;
    logic                   salida_valido;
    logic [ANCHO_DATOS-1:0] salidaMemoriaDeInstrucciones;
    logic                   salida_listo;
    logic                   error_dir;

    modport master (
        output dir_valido,
        output dir,
        input  dir_listo,
        input  salida_valido,
        input  salidaMemoriaDeInstrucciones,
        output salida_listo,
        input  error_dir
    );

    modport slave (
        input  dir_valido,
        input  dir,
        output dir_listo,
        output salida_valido,
        output salidaMemoriaDeInstrucciones,
        input  salida_listo,
        output error_dir
    );

endinterface

// File: rtl/arreglo_memoria.sv
// Instruction storage: one write port for boot-load and one synchronous read port
// whose output register only changes when a read is enabled.
module arreglo_memoria #(
    parameter int unsigned ANCHO_DATOS  = 32,
    parameter int unsigned PROFUNDIDAD  = 256,
    parameter int unsigned ANCHO_INDICE = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ANCHO_INDICE-1:0] wr_indice,
    input  logic [ANCHO_DATOS-1:0]  wr_dato,
    input  logic                    rd_en,
    input  logic [ANCHO_INDICE-1:0] rd_indice,
    output logic [ANCHO_DATOS-1:0]  rd_dato
);

    logic [ANCHO_DATOS-1:0] mem [PROFUNDIDAD];
    logic [ANCHO_DATOS-1:0] rd_dato_d, rd_dato_q;

    // The array itself is never reset so the program survives a processor reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_indice] <= wr_dato;
        end
    end

    always_comb begin
        rd_dato_d = rd_dato_q;
        if (rd_en) begin
            rd_dato_d = mem[rd_indice];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_dato_q <= '0;
        end else begin
            rd_dato_q <= rd_dato_d;
        end
    end

    assign rd_dato = rd_dato_q;

endmodule

// File: rtl/memoria_instrucciones_param.sv
// Instruction memory: boot-load FSM, fetch address checks, valid/ready handshake
// and response register with one-cycle fetch latency.
module memoria_instrucciones_param
    import memoria_pkg::*;
#(
    parameter int unsigned ANCHO_DATOS      = 32,
    parameter int unsigned PROFUNDIDAD      = 256,
    parameter int unsigned ANCHO_DIR        = 32,
    parameter bit          INICIO_EJECUCION = 1'b0
) (
    input  logic                             clk,
    input  logic                             reset,
    memoria_instrucciones_param_if.slave     bus,
    input  logic                             carga_en,
    input  logic [clog2(PROFUNDIDAD)-1:0]    carga_dir,
    input  logic [ANCHO_DATOS-1:0]           carga_dato,
    input  logic                             carga_fin,
    output logic                             en_ejecucion
);

    localparam int unsigned BYTES      = ANCHO_DATOS / 8;
    localparam int unsigned LOG2_BYTES = clog2(BYTES);
    localparam int unsigned LOG2_PROF  = clog2(PROFUNDIDAD);

    localparam logic [ANCHO_DIR-1:0] MASCARA_ALINEO =
        ANCHO_DIR'((64'd1 << LOG2_BYTES) - 64'd1);
    // One extra bit so the byte limit is representable even when it equals 2**ANCHO_DIR.
    localparam logic [ANCHO_DIR:0] LIMITE =
        (ANCHO_DIR + 1)'(64'(PROFUNDIDAD) * 64'(BYTES));

    localparam estado_e ESTADO_RESET = INICIO_EJECUCION ? ESTADO_EJECUCION : ESTADO_CARGA;

    estado_e estado_d, estado_q;

    logic                 salida_valido_d, salida_valido_q;
    logic                 error_dir_d, error_dir_q;
    logic                 desalineado;
    logic                 fuera_rango;
    logic                 error_fetch;
    logic                 aceptado;
    logic                 escritura;
    logic                 lectura;
    logic [LOG2_PROF-1:0] indice;
    logic [ANCHO_DATOS-1:0] rd_dato;

    // FSM: CARGA until carga_fin, then EJECUCION until reset.
    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            ESTADO_CARGA:     if (carga_fin) estado_d = ESTADO_EJECUCION;
            ESTADO_EJECUCION: estado_d = ESTADO_EJECUCION;
            default:          estado_d = ESTADO_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= ESTADO_RESET;
        end else begin
            estado_q <= estado_d;
        end
    end

    assign en_ejecucion = (estado_q == ESTADO_EJECUCION);
    assign escritura    = carga_en && (estado_q == ESTADO_CARGA);

    assign desalineado = |(bus.dir & MASCARA_ALINEO);
    assign fuera_rango = ({1'b0, bus.dir} >= LIMITE);
    assign error_fetch = desalineado || fuera_rango;
    assign indice      = LOG2_PROF'(bus.dir >> LOG2_BYTES);

    // A slot opens when the response register is empty or being drained this cycle.
    assign bus.dir_listo = en_ejecucion && (!salida_valido_q || bus.salida_listo);
    assign aceptado      = bus.dir_valido && bus.dir_listo;
    assign lectura       = aceptado && !error_fetch;

    always_comb begin
        salida_valido_d = salida_valido_q;
        error_dir_d     = error_dir_q;
        if (aceptado) begin
            salida_valido_d = 1'b1;
            error_dir_d     = error_fetch;
        end else if (bus.salida_listo) begin
            salida_valido_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            salida_valido_q <= 1'b0;
            error_dir_q     <= 1'b0;
        end else begin
            salida_valido_q <= salida_valido_d;
            error_dir_q     <= error_dir_d;
        end
    end

    arreglo_memoria #(
        .ANCHO_DATOS  (ANCHO_DATOS),
        .PROFUNDIDAD  (PROFUNDIDAD),
        .ANCHO_INDICE (LOG2_PROF)
    ) u_arreglo (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (escritura),
        .wr_indice (carga_dir),
        .wr_dato   (carga_dato),
        .rd_en     (lectura),
        .rd_indice (indice),
        .rd_dato   (rd_dato)
    );

    // Errored responses skip the array read, so the stale read register is masked to NOP.
    assign bus.salidaMemoriaDeInstrucciones = error_dir_q ? NOP[ANCHO_DATOS-1:0] : rd_dato;
    assign bus.salida_valido                = salida_valido_q;
    assign bus.error_dir                    = error_dir_q;

endmodule

// File: tb/tb_memoria_instrucciones_param.sv
// Directed bench: one instance booting in CARGA, one booting in EJECUCION.
module tb_memoria_instrucciones_param;

    localparam logic [31:0] INSTR_A = 32'h014A1820;
    localparam logic [31:0] INSTR_B = 32'h8C020004;

    logic       clk;
    logic       reset;
    logic       carga_en;
    logic [7:0] carga_dir;
    logic [31:0] carga_dato;
    logic       carga_fin;
    logic       en_ejecucion0;
    logic       en_ejecucion1;

    int checks;
    int errors;

    memoria_instrucciones_param_if #(.ANCHO_DATOS(32), .ANCHO_DIR(32)) bus0 ();
    memoria_instrucciones_param_if #(.ANCHO_DATOS(32), .ANCHO_DIR(32)) bus1 ();

    memoria_instrucciones_param #(
        .ANCHO_DATOS      (32),
        .PROFUNDIDAD      (256),
        .ANCHO_DIR        (32),
        .INICIO_EJECUCION (1'b0)
    ) dut0 (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus0),
        .carga_en     (carga_en),
        .carga_dir    (carga_dir),
        .carga_dato   (carga_dato),
        .carga_fin    (carga_fin),
        .en_ejecucion (en_ejecucion0)
    );

    memoria_instrucciones_param #(
        .ANCHO_DATOS      (32),
        .PROFUNDIDAD      (256),
        .ANCHO_DIR        (32),
        .INICIO_EJECUCION (1'b1)
    ) dut1 (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus1),
        .carga_en     (1'b0),
        .carga_dir    (8'd0),
        .carga_dato   (32'd0),
        .carga_fin    (1'b0),
        .en_ejecucion (en_ejecucion1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        carga_en = 1'b0;
        carga_dir = '0;
        carga_dato = '0;
        carga_fin = 1'b0;
        bus0.dir_valido = 1'b0;
        bus0.dir = '0;
        bus0.salida_listo = 1'b0;
        bus1.dir_valido = 1'b0;
        bus1.dir = '0;
        bus1.salida_listo = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;

        check_eq("rst_valido0", 64'(bus0.salida_valido), 64'd0);
        check_eq("rst_dato0", 64'(bus0.salidaMemoriaDeInstrucciones), 64'd0);
        check_eq("rst_err0", 64'(bus0.error_dir), 64'd0);
        check_eq("rst_en0", 64'(en_ejecucion0), 64'd0);
        check_eq("rst_listo0", 64'(bus0.dir_listo), 64'd0);
        check_eq("rst_en1", 64'(en_ejecucion1), 64'd1);
        check_eq("rst_listo1", 64'(bus1.dir_listo), 64'd1);

        // dut1 fetches out of range straight away; dut0 loads word 0 and tries to fetch.
        bus1.dir_valido = 1'b1;
        bus1.dir = 32'd1024;
        carga_en = 1'b1;
        carga_dir = 8'd0;
        carga_dato = INSTR_A;
        bus0.dir_valido = 1'b1;
        bus0.dir = 32'd0;
        step();
        bus1.dir_valido = 1'b0;
        check_eq("carga_listo0", 64'(bus0.dir_listo), 64'd0);
        check_eq("carga_valido0", 64'(bus0.salida_valido), 64'd0);
        check_eq("oor_valido1", 64'(bus1.salida_valido), 64'd1);
        check_eq("oor_err1", 64'(bus1.error_dir), 64'd1);
        check_eq("oor_dato1", 64'(bus1.salidaMemoriaDeInstrucciones), 64'd0);
        check_eq("stall_listo1", 64'(bus1.dir_listo), 64'd0);

        // Last write together with carga_fin.
        carga_dir = 8'd1;
        carga_dato = INSTR_B;
        carga_fin = 1'b1;
        step();
        carga_en = 1'b0;
        carga_fin = 1'b0;
        check_eq("fin_en0", 64'(en_ejecucion0), 64'd1);
        check_eq("fin_valido0", 64'(bus0.salida_valido), 64'd0);
        bus0.salida_listo = 1'b1;
        #1;
        check_eq("ejec_listo0", 64'(bus0.dir_listo), 64'd1);

        step();
        check_eq("fetch0_valido", 64'(bus0.salida_valido), 64'd1);
        check_eq("fetch0_dato", 64'(bus0.salidaMemoriaDeInstrucciones), 64'(INSTR_A));
        check_eq("fetch0_err", 64'(bus0.error_dir), 64'd0);
        bus0.dir = 32'd4;
        step();
        check_eq("fetch4_valido", 64'(bus0.salida_valido), 64'd1);
        check_eq("fetch4_dato", 64'(bus0.salidaMemoriaDeInstrucciones), 64'(INSTR_B));
        check_eq("fetch4_err", 64'(bus0.error_dir), 64'd0);

        bus0.dir = 32'd2;
        step();
        check_eq("desal_dato", 64'(bus0.salidaMemoriaDeInstrucciones), 64'd0);
        check_eq("desal_err", 64'(bus0.error_dir), 64'd1);
        bus0.dir = 32'd1024;
        step();
        check_eq("oor_dato0", 64'(bus0.salidaMemoriaDeInstrucciones), 64'd0);
        check_eq("oor_err0", 64'(bus0.error_dir), 64'd1);
        bus0.dir = 32'd1020;
        step();
        check_eq("ultima_err", 64'(bus0.error_dir), 64'd0);
        check_eq("ultima_valido", 64'(bus0.salida_valido), 64'd1);
        bus0.dir = 32'd1023;
        step();
        check_eq("ultima_desal_err", 64'(bus0.error_dir), 64'd1);

        // Backpressure on a fetch of word 1.
        bus0.dir = 32'd4;
        step();
        check_eq("bp_dato_ini", 64'(bus0.salidaMemoriaDeInstrucciones), 64'(INSTR_B));
        bus0.salida_listo = 1'b0;
        bus0.dir = 32'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("bp_listo", 64'(bus0.dir_listo), 64'd0);
            check_eq("bp_dato", 64'(bus0.salidaMemoriaDeInstrucciones), 64'(INSTR_B));
            check_eq("bp_valido", 64'(bus0.salida_valido), 64'd1);
            step();
        end
        bus0.salida_listo = 1'b1;
        #1;
        check_eq("bp_libera_listo", 64'(bus0.dir_listo), 64'd1);
        step();
        check_eq("bp_sig_dato", 64'(bus0.salidaMemoriaDeInstrucciones), 64'(INSTR_A));
        check_eq("bp_sig_valido", 64'(bus0.salida_valido), 64'd1);

        // Load port must be inert once executing.
        bus0.dir_valido = 1'b0;
        carga_en = 1'b1;
        carga_dir = 8'd0;
        carga_dato = 32'hFFFF_FFFF;
        carga_fin = 1'b1;
        step();
        carga_en = 1'b0;
        carga_fin = 1'b0;
        check_eq("ign_en0", 64'(en_ejecucion0), 64'd1);
        check_eq("ign_vacio", 64'(bus0.salida_valido), 64'd0);
        bus0.dir_valido = 1'b1;
        bus0.dir = 32'd0;
        step();
        bus0.dir_valido = 1'b0;
        check_eq("ign_dato", 64'(bus0.salidaMemoriaDeInstrucciones), 64'(INSTR_A));
        check_eq("pre_rst_valido1", 64'(bus1.salida_valido), 64'd1);

        // Reset with responses pending in both instances.
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("mid_rst_valido0", 64'(bus0.salida_valido), 64'd0);
        check_eq("mid_rst_en0", 64'(en_ejecucion0), 64'd0);
        check_eq("mid_rst_dato0", 64'(bus0.salidaMemoriaDeInstrucciones), 64'd0);
        check_eq("mid_rst_valido1", 64'(bus1.salida_valido), 64'd0);
        check_eq("mid_rst_en1", 64'(en_ejecucion1), 64'd1);

        // Memory survives reset: skip the load and fetch word 0 again.
        carga_fin = 1'b1;
        step();
        carga_fin = 1'b0;
        bus0.dir_valido = 1'b1;
        bus0.dir = 32'd0;
        step();
        bus0.dir_valido = 1'b0;
        check_eq("retiene_dato", 64'(bus0.salidaMemoriaDeInstrucciones), 64'(INSTR_A));
        check_eq("retiene_valido", 64'(bus0.salida_valido), 64'd1);
        step();
        check_eq("consumido_valido", 64'(bus0.salida_valido), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
